hilo_muldiv_ctrl: RTL and testbench
===================================

// Module: hilo_muldiv_ctrl
// PURPOSE
//  Sequencer for the HI/LO special register pair. It takes MULT/DIV/MTHI/MTLO requests from EX.
//  It runs an iterative multiply or divide, stalls the pipeline while busy, and issues one
//  write pulse (wr_en, hi, lo) to the HI/LO register file. It is the only writer of HI/LO.
// PARAMETERS
//  WIDTH     32  operand width; hi/lo are WIDTH bits each
//  FAST_MUL  0   1: MULT/MULTU use one registered product cycle; 0: shift-add, WIDTH iterations
// PORTS
//  clk     in   1      system clock, rising edge
//  rst     in   1      asynchronous, active-low reset
//  start   in   1      request valid; sampled only in IDLE
//  op      in   4      0 MULT,1 MULTU,2 DIV,3 DIVU,4 MTHI,5 MTLO,6 MADD,7 MADDU,8 MSUB,9 MSUBU
//  src_a   in   WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO data)
//  src_b   in   WIDTH  rt operand (multiplier / divisor)
//  hi_cur  in   WIDTH  current HI contents (used by MTLO and accumulate)
//  lo_cur  in   WIDTH  current LO contents (used by MTHI and accumulate)
//  flush   in   1      pipeline flush/exception; cancels request
//  busy    out  1      stall request to pipeline control
//  wr_en   out  1      one-cycle HI/LO write strobe
//  hi      out  WIDTH  HI write data, valid while wr_en
//  lo      out  WIDTH  LO write data, valid while wr_en
// BEHAVIOUR
//  - Reset (rst low, async): state=IDLE, busy=0, wr_en=0, hi=0, lo=0, counter=0.
//  - Reset mid-operation aborts the operation with no write.
//  - FSM: IDLE -> MUL|DIV -> DONE -> IDLE. busy = (state != IDLE). wr_en = (state==DONE) & ~flush.
//  - Accept: rising edge with state==IDLE, start=1, flush=0, legal op. The edge latches
//    op, src_a, src_b, hi_cur and lo_cur. Later input changes are ignored.
//  - Illegal op, or start while busy: ignored, no state change.
//  - Cycle n = nth cycle after the accepting edge.
//  - MTHI/MTLO: -> DONE. Cycle 1: wr_en=1. MTHI: hi=src_a, lo=lo_cur. MTLO: hi=hi_cur, lo=src_a.
//  - MULT(U), FAST_MUL=0: signed ops are converted to magnitudes. WIDTH shift-add iterations.
//    Sign fix (negate if signs differ) on entry to DONE. busy cycles 1..33, wr_en cycle 33 only.
//    {hi,lo} = 64-bit product.
//  - MULT(U), FAST_MUL=1: MUL is skipped and the product is registered directly into DONE.
//    busy and wr_en in cycle 1.
//  - DIV(U): radix-2 restoring divide on magnitudes, WIDTH iterations; same timing as shift-add MULT.
//    lo=quotient, hi=remainder.
//    Signed: quotient negative iff operand signs differ; remainder takes the dividend sign.
//    0x80000000 / 0xFFFFFFFF (signed) -> lo=0x80000000, hi=0 (natural wrap, no trap).
//  - Divide by zero: DIV is skipped -> DONE. Cycle 1: wr_en=1, hi=src_a, lo={WIDTH{1'b1}}.
//  - flush while busy: next edge -> IDLE, counter cleared, no wr_en.
//    flush during DONE gates wr_en low combinationally.
//    flush together with start in IDLE: request not accepted.
//  - On the edge leaving DONE, the next request may be accepted in the following IDLE cycle
//    (one idle cycle minimum between operations).
//  - hi/lo hold the last written values while wr_en=0.
// CONFIGURATION
//  - Macro HILO_MADD_EN defined: ops 6-9 are legal.
//    They use the MUL path (timing per FAST_MUL), then a 64-bit add/sub with the latched
//    {hi_cur,lo_cur} in DONE.
//    MADD/MSUB: signed product; MADDU/MSUBU: unsigned product. Result is {hi_cur,lo_cur} +/- product, mod 2^64.
//  - Macro HILO_MADD_EN undefined: ops 6-9 are illegal (ignored, no busy) and no accumulate adder is built.
// TESTING
//  1. MULT src_a=0xFFFFFFFD (-3), src_b=7, FAST_MUL=0
//     -> busy cycles 1..33; wr_en only cycle 33; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
//  2. DIVU 100/7 -> cycle 33: lo=14, hi=2.
//     DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//  3. DIV src_a=5, src_b=0 -> cycle 1: wr_en=1, hi=5, lo=0xFFFFFFFF; busy low in cycle 2.
//  4. DIVU start, flush=1 in cycle 10 -> busy=0 from cycle 11, no wr_en.
//     Next MTLO 0x55 with hi_cur=0x9 -> hi=0x9, lo=0x55.
//  5. MTHI src_a=0x1234, lo_cur=0xABCD -> cycle 1: wr_en=1, hi=0x1234, lo=0xABCD.
//     rst pulsed low in cycle 5 of a MULT -> all outputs 0, no write.
//  6. HILO_MADD_EN: MADDU hi_cur=0, lo_cur=0xFFFFFFFF, a=1, b=1 -> hi=1, lo=0.
//     Without the macro, op 7 -> busy stays 0, no wr_en.

Source files
------------

// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl: sequencer that owns all writes to the HI/LO register pair.
// It handles MULT/MULTU (shift-add, or a single registered product when FAST_MUL=1),
// DIV/DIVU (radix-2 restoring), and MTHI/MTLO. Each accepted request ends in exactly
// one wr_en pulse carrying the new {hi, lo}.
// Optional feature macro: HILO_MADD_EN adds MADD/MADDU/MSUB/MSUBU (ops 6-9), which
// accumulate the product into the HI/LO value latched at accept.
//
// Handshake: a request is taken on a rising edge when the FSM is IDLE, start=1,
// flush=0 and op is legal. busy stays high from the next cycle until the DONE cycle
// ends. wr_en is a one-cycle strobe in DONE, and flush forces it low in that cycle.
module hilo_muldiv_ctrl #(
    parameter int WIDTH    = 32,
    parameter bit FAST_MUL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [WIDTH-1:0] hi_cur,
    input  logic [WIDTH-1:0] lo_cur,
    input  logic             flush,
    output logic             busy,
    output logic             wr_en,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MTHI  = 4'd4;
    localparam logic [3:0] OP_MTLO  = 4'd5;
`ifdef HILO_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd6;
    localparam logic [3:0] OP_MADDU = 4'd7;
    localparam logic [3:0] OP_MSUB  = 4'd8;
    localparam logic [3:0] OP_MSUBU = 4'd9;
`endif

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
    state_t state, state_nxt;

    // Working registers: acc_hi/acc_lo hold the partial product or the remainder/quotient.
    // Once the FSM reaches DONE they hold the final result.
    logic [WIDTH-1:0] acc_hi, acc_lo, mcand_q, out_hi, out_lo;
    logic             neg_q, rem_neg_q;
    logic [CW-1:0]    cnt;
`ifdef HILO_MADD_EN
    logic [3:0]       op_q;
    logic [WIDTH-1:0] hic_q, loc_q;
    logic [2*WIDTH-1:0] acc_base;
    logic [3:0]       acc_op;
`endif

    logic is_mul, is_div, is_mt, is_sgn, op_legal, accept;
    logic a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_sum;
    logic [2*WIDTH-1:0] fast_prod, mul_next, mul_raw, mul_signed, mul_result;
    logic mul_neg;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff, rem_next, quo_next, rem_final, quo_final;
    logic div_ge;

    // Decode the request, and convert signed operands to magnitudes
    always_comb begin
        is_mul = (op == OP_MULT) || (op == OP_MULTU);
        is_sgn = (op == OP_MULT) || (op == OP_DIV);
`ifdef HILO_MADD_EN
        is_mul = is_mul || (op == OP_MADD) || (op == OP_MADDU) ||
                 (op == OP_MSUB) || (op == OP_MSUBU);
        is_sgn = is_sgn || (op == OP_MADD) || (op == OP_MSUB);
`endif
        is_div   = (op == OP_DIV) || (op == OP_DIVU);
        is_mt    = (op == OP_MTHI) || (op == OP_MTLO);
        op_legal = is_mul || is_div || is_mt;
        a_neg    = is_sgn && src_a[WIDTH-1];
        b_neg    = is_sgn && src_b[WIDTH-1];
        a_mag    = a_neg ? -src_a : src_a;
        b_mag    = b_neg ? -src_b : src_b;
    end

    assign accept = (state == S_IDLE) && start && !flush && op_legal;

    // Multiply step, final sign fix and optional accumulate (used for the fast and iterative paths)
    always_comb begin
        fast_prod  = (2*WIDTH)'(a_mag) * (2*WIDTH)'(b_mag);
        mul_sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand_q} : '0);
        mul_next   = {mul_sum, acc_lo[WIDTH-1:1]};
        mul_raw    = (state == S_IDLE) ? fast_prod : mul_next;
        mul_neg    = (state == S_IDLE) ? (a_neg ^ b_neg) : neg_q;
        mul_signed = mul_neg ? -mul_raw : mul_raw;
`ifdef HILO_MADD_EN
        acc_base = (state == S_IDLE) ? {hi_cur, lo_cur} : {hic_q, loc_q};
        acc_op   = (state == S_IDLE) ? op : op_q;
        case (acc_op)
            OP_MADD, OP_MADDU: mul_result = acc_base + mul_signed;
            OP_MSUB, OP_MSUBU: mul_result = acc_base - mul_signed;
            default:           mul_result = mul_signed;
        endcase
`else
        mul_result = mul_signed;
`endif
    end

    // Restoring divide step; the sign fix is applied only to the final iteration
    always_comb begin
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, mcand_q};
        div_diff  = div_shift[WIDTH-1:0] - mcand_q;
        rem_next  = div_ge ? div_diff : div_shift[WIDTH-1:0];
        quo_next  = {acc_lo[WIDTH-2:0], div_ge};
        quo_final = neg_q ? -quo_next : quo_next;
        rem_final = rem_neg_q ? -rem_next : rem_next;
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic and control outputs
    always_comb begin
        state_nxt = state;
        busy      = (state != S_IDLE);
        wr_en     = (state == S_DONE) && !flush;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (is_mt)                      state_nxt = S_DONE;
                    else if (is_div)                state_nxt = (src_b == '0) ? S_DONE : S_DIV;
                    else                            state_nxt = FAST_MUL ? S_DONE : S_MUL;
                end
            end
            S_MUL, S_DIV: begin
                if (flush)             state_nxt = S_IDLE;
                else if (cnt == LAST)  state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: latch operands on accept, iterate, and keep the last written HI/LO
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_hi    <= '0;
            acc_lo    <= '0;
            mcand_q   <= '0;
            out_hi    <= '0;
            out_lo    <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            cnt       <= '0;
`ifdef HILO_MADD_EN
            op_q      <= '0;
            hic_q     <= '0;
            loc_q     <= '0;
`endif
        end else begin
            if (wr_en) begin
                out_hi <= acc_hi;
                out_lo <= acc_lo;
            end
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cnt       <= '0;
                        neg_q     <= a_neg ^ b_neg;
                        rem_neg_q <= a_neg;
                        acc_hi    <= '0;
`ifdef HILO_MADD_EN
                        op_q      <= op;
                        hic_q     <= hi_cur;
                        loc_q     <= lo_cur;
`endif
                        if (is_mt) begin
                            acc_hi <= (op == OP_MTHI) ? src_a : hi_cur;
                            acc_lo <= (op == OP_MTHI) ? lo_cur : src_a;
                        end else if (is_div) begin
                            mcand_q <= b_mag;
                            if (src_b == '0) begin
                                acc_hi <= src_a;
                                acc_lo <= '1;
                            end else begin
                                acc_lo <= a_mag;
                            end
                        end else begin
                            mcand_q <= a_mag;
                            if (FAST_MUL) {acc_hi, acc_lo} <= mul_result;
                            else          acc_lo <= b_mag;
                        end
                    end
                end
                S_MUL: begin
                    if (flush) begin
                        cnt <= '0;
                    end else if (cnt == LAST) begin
                        cnt <= '0;
                        {acc_hi, acc_lo} <= mul_result;
                    end else begin
                        cnt <= cnt + 1'b1;
                        {acc_hi, acc_lo} <= mul_next;
                    end
                end
                S_DIV: begin
                    if (flush) begin
                        cnt <= '0;
                    end else if (cnt == LAST) begin
                        cnt    <= '0;
                        acc_hi <= rem_final;
                        acc_lo <= quo_final;
                    end else begin
                        cnt    <= cnt + 1'b1;
                        acc_hi <= rem_next;
                        acc_lo <= quo_next;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

    // Write data comes from the result registers during the strobe, otherwise it holds
    assign hi = wr_en ? acc_hi : out_hi;
    assign lo = wr_en ? acc_lo : out_lo;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// tb_hilo_muldiv_ctrl: directed plus random bench for the HI/LO sequencer.
// For each request it pushes the expected {hi,lo} when the request is driven. It pops
// that value and compares it when wr_en is seen, and it checks busy/wr_en every cycle.
module tb_hilo_muldiv_ctrl;

    localparam bit FAST_MUL = 1'b0;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  op;
    logic [31:0] src_a, src_b, hi_cur, lo_cur;
    logic        flush;
    logic        busy, wr_en;
    logic [31:0] hi, lo;

    logic [63:0] exp_q[$];
    logic [63:0] last;
    int          vectors = 0;
    int          fails   = 0;

    hilo_muldiv_ctrl #(.WIDTH(32), .FAST_MUL(FAST_MUL)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .hi_cur(hi_cur), .lo_cur(lo_cur),
        .flush(flush), .busy(busy), .wr_en(wr_en), .hi(hi), .lo(lo)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model of the HI/LO result
    function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] hc,
                                          input logic [31:0] lc);
        logic signed [63:0] sa, sb, q, r;
        logic [63:0] ua, ub, base;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        base = {hc, lc};
        model = 64'b0;
        case (o)
            4'd0: model = sa * sb;
            4'd1: model = ua * ub;
            4'd2: begin
                if (b == 32'b0) model = {a, 32'hFFFFFFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    model = {r[31:0], q[31:0]};
                end
            end
            4'd3: begin
                if (b == 32'b0) model = {a, 32'hFFFFFFFF};
                else            model = {a % b, a / b};
            end
            4'd4: model = {a, lc};
            4'd5: model = {hc, a};
            4'd6: model = base + sa * sb;
            4'd7: model = base + ua * ub;
            4'd8: model = base - sa * sb;
            4'd9: model = base - ua * ub;
            default: model = 64'b0;
        endcase
    endfunction

    function automatic int lat_of(input logic [3:0] o, input logic [31:0] b);
        if (o == 4'd4 || o == 4'd5) return 1;
        if (o == 4'd2 || o == 4'd3) return (b == 32'b0) ? 1 : 33;
        return FAST_MUL ? 1 : 33;
    endfunction

    // Pop and compare one scoreboard entry on an observed write strobe
    task automatic sb_pop();
        logic [63:0] e;
        if (exp_q.size() == 0) begin
            check("unexpected_wr", {hi, lo}, last);
        end else begin
            e = exp_q.pop_front();
            check("hilo_wr", {hi, lo}, e);
        end
    endtask

    // Drive one request, check busy/wr_en each cycle, and check that HI/LO hold afterwards
    task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] hc, input logic [31:0] lc);
        int lat;
        logic [63:0] e;
        lat = lat_of(o, b);
        e   = model(o, a, b, hc, lc);
        @(negedge clk);
        op = o; src_a = a; src_b = b; hi_cur = hc; lo_cur = lc; start = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(e);
        start = 1'b0;
        src_a = $urandom; src_b = $urandom; hi_cur = $urandom; lo_cur = $urandom;
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            check("busy_run", {63'b0, busy}, 64'd1);
            check("wr_en_run", {63'b0, wr_en}, {63'b0, (c == lat)});
            if (wr_en === 1'b1) sb_pop();
            start = 1'($urandom_range(0, 1));
            op    = 4'($urandom_range(0, 5));
        end
        @(negedge clk);
        start = 1'b0;
        check("busy_after", {63'b0, busy}, 64'd0);
        check("hilo_hold", {hi, lo}, e);
        last = e;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; op = 4'd0; flush = 1'b0;
        src_a = '0; src_b = '0; hi_cur = '0; lo_cur = '0;
        last = 64'b0;
        #12;
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_wr_en", {63'b0, wr_en}, 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // MULT -3 * 7
        do_op(4'd0, 32'hFFFFFFFD, 32'd7, 32'h0, 32'h0);
        check("mult_neg3x7", last, 64'hFFFFFFFF_FFFFFFEB);
        // Divides, including the signed overflow case and divide-by-zero
        do_op(4'd3, 32'd100, 32'd7, 32'h0, 32'h0);
        check("divu_100_7", last, {32'd2, 32'd14});
        do_op(4'd2, 32'hFFFFFFF9, 32'd2, 32'h0, 32'h0);
        check("div_neg7_2", last, 64'hFFFFFFFF_FFFFFFFD);
        do_op(4'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h0);
        check("div_ovf", last, 64'h00000000_80000000);
        do_op(4'd2, 32'd5, 32'd0, 32'h0, 32'h0);
        check("div_by_zero", last, 64'h00000005_FFFFFFFF);
        do_op(4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0);

        // DIVU flushed in cycle 10: no write, idle from cycle 11
        @(negedge clk);
        op = 4'd3; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            check("flush_busy", {63'b0, busy}, 64'd1);
            check("flush_wr_en", {63'b0, wr_en}, 64'd0);
        end
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        check("flush_idle", {63'b0, busy}, 64'd0);
        check("flush_no_wr", {63'b0, wr_en}, 64'd0);
        check("flush_hold", {hi, lo}, last);
        flush = 1'b0;

        do_op(4'd5, 32'h55, 32'h0, 32'h9, 32'h0);
        check("mtlo", last, {32'h9, 32'h55});
        do_op(4'd4, 32'h1234, 32'h0, 32'h0, 32'hABCD);
        check("mthi", last, {32'h1234, 32'hABCD});

        // Reset in cycle 5 of a MULT aborts it
        @(negedge clk);
        op = 4'd0; src_a = 32'd12345; src_b = 32'd678; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 4; c++) @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_busy", {63'b0, busy}, 64'd0);
        check("mid_rst_wr_en", {63'b0, wr_en}, 64'd0);
        check("mid_rst_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        last = 64'b0;
        @(negedge clk);
        check("post_rst_idle", {63'b0, busy}, 64'd0);

        // Requests that must be ignored
        start = 1'b1; flush = 1'b1; op = 4'd4;
        @(negedge clk);
        check("flush_start", {63'b0, busy}, 64'd0);
        flush = 1'b0; op = 4'd10;
        @(negedge clk);
        check("illegal_10", {63'b0, busy}, 64'd0);
        op = 4'd15;
        @(negedge clk);
        check("illegal_15", {63'b0, busy}, 64'd0);
        start = 1'b0;
`ifdef HILO_MADD_EN
        do_op(4'd7, 32'd1, 32'd1, 32'h0, 32'hFFFFFFFF);
        check("maddu", last, 64'h00000001_00000000);
        do_op(4'd8, 32'hFFFFFFFE, 32'd3, 32'd0, 32'd10);
`else
        @(negedge clk);
        op = 4'd7; src_a = 32'd1; src_b = 32'd1; lo_cur = 32'hFFFFFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("op7_ignored", {63'b0, busy}, 64'd0);
        check("op7_no_wr", {63'b0, wr_en}, 64'd0);
`endif

        // Flush during DONE suppresses the strobe
        @(negedge clk);
        op = 4'd4; src_a = 32'hDEAD; lo_cur = 32'hBEEF; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; flush = 1'b1;
        @(negedge clk);
        check("done_flush_busy", {63'b0, busy}, 64'd1);
        check("done_flush_wr", {63'b0, wr_en}, 64'd0);
        check("done_flush_hold", {hi, lo}, last);
        @(negedge clk);
        check("done_flush_idle", {63'b0, busy}, 64'd0);
        flush = 1'b0;

        // Random operations
        for (int i = 0; i < 10; i++) begin
            logic [3:0]  ro;
            logic [31:0] rb;
            ro = 4'($urandom_range(0, 5));
            rb = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            do_op(ro, $urandom, rb, $urandom, $urandom);
        end

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
